ads1115_i2c_target: RTL and testbench
=====================================

ADS1115_I2C_TARGET -- requirements
Module: ads1115_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h48, 7-bit I2C address the block answers to.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 scl_in  input  1  SCL pin level, asynchronous to clk.
REQ-005 sda_in  input  1  SDA pin level, asynchronous to clk.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 conv_data  input  16  new conversion result, two's complement.
REQ-008 conv_valid  input  1  single-cycle strobe; loads conv_data into the conversion register.
REQ-009 cfg_reg  output  16  current config register (pointer 1).
REQ-010 cfg_wr  output  1  one-cycle pulse when cfg_reg is updated from the bus.
REQ-011 os_start  output  1  one-cycle pulse with cfg_wr when the written config bit 15 = 1.

Function
REQ-012 SHALL pass scl_in/sda_in through 2-flop synchronisers plus one history flop; edge detection uses synchronised levels only.
REQ-013 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both SHALL be detected in any state.
REQ-014 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-015 START (incl. repeated START) SHALL enter ADDR with bit counter 0; STOP SHALL enter IDLE and release SDA.
REQ-016 Bits SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only on the cycle after an SCL falling edge is detected.
REQ-017 ADDR: after 8 bits, address match -> ADDR_ACK (drive 0 for one SCL period); mismatch -> WAIT_STOP with SDA released.
REQ-018 R/W = 0 -> PTR; R/W = 1 -> RDATA, snapshotting the addressed register into a 16-bit shift buffer at ADDR_ACK.
REQ-019 PTR: byte[1:0] loads the pointer register; ACK always; byte[7:2] ignored.
REQ-020 WDATA: first byte -> MSB holding latch, second byte -> LSB; register commit on the LSB's ACK cycle; a third and later byte SHALL be NACKed (SDA released) and go to WAIT_STOP.
REQ-021 Pointer 0 (conversion) is read-only; write data to it SHALL be ACKed and discarded.
REQ-022 RDATA: target drives MSB then LSB, SDA changing only while SCL low; after each byte, RDATA_ACK samples master ACK: ACK (0) -> next byte, wrapping MSB->LSB->MSB of the same snapshot; NACK (1) -> WAIT_STOP.
REQ-023 Read without prior pointer write in the same transaction SHALL use the retained pointer value.
REQ-024 conv_valid SHALL update the conversion register in any state; an in-flight read returns the snapshot, never a torn value.
REQ-025 cfg_wr/os_start SHALL assert exactly one clk cycle after commit to pointer 1; STOP before the LSB completes SHALL leave the register unchanged.

Reset
REQ-026 rst SHALL immediately set: state IDLE, sda_oe 0, pointer 2'b00, conversion 16'h0000, cfg_reg 16'h8583, lo_thresh 16'h8000, hi_thresh 16'h7FFF, cfg_wr 0, os_start 0, synchronisers to 1.
REQ-027 rst asserted mid-transaction SHALL release SDA in the same cycle; the block SHALL then ignore bus activity until the next START.

Configuration
REQ-028 Macro ADS1115_TARGET_THRESH_EN defined: pointers 2 (lo_thresh) and 3 (hi_thresh) SHALL be read/write 16-bit registers.
REQ-029 Macro undefined: pointers 2/3 SHALL read 16'h0000, writes ACKed and discarded, no threshold flops synthesised.

Structure
REQ-030 Shared package holds the state encoding, pointer constants (PTR_CONV=0, PTR_CFG=1, PTR_LO=2, PTR_HI=3), and reset values of the register file.
REQ-031 One sub-module, i2c_bus_monitor: synchronisers, SCL rise/fall, START, STOP detection.

Verification
REQ-032 Write 0x90,0x01,0x84,0x83 -> three ACKs at the ACK slots, fourth-byte ACK, cfg_reg = 16'h8483, cfg_wr and os_start pulse once.
REQ-033 conv_valid with 16'h1234; write 0x90,0x00; repeated START; 0x91; read 2 bytes, master NACKs last -> bytes 0x12, 0x34.
REQ-034 Address 0x92 (7'h49) -> SDA never driven low through the following STOP.
REQ-035 During read of conversion, conv_valid with 16'hABCD between MSB and LSB -> second byte is from the old snapshot; next transaction returns 0xAB, 0xCD.
REQ-036 Write 0x90,0x03,0x7F,0x00 -> with macro: read of pointer 3 returns 0x7F00; without: returns 0x0000.
REQ-037 rst pulsed while target drives an ACK low -> sda_oe 0 same cycle, cfg_reg 16'h8583, then a fresh transaction is ACKed normally.

Source files
------------

// File: rtl/ads1115_i2c_target_pkg.sv
// Shared definitions for the ADS1115-style I2C target: state encoding, pointer
// codes, register reset values and a snapshot byte selector.
package ads1115_i2c_target_pkg;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_PTR       = 4'd3;
   localparam logic [3:0] ST_PTR_ACK   = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] ST_RDATA     = 4'd7;
   localparam logic [3:0] ST_RDATA_ACK = 4'd8;
   localparam logic [3:0] ST_WAIT_STOP = 4'd9;

   localparam logic [1:0] PTR_CONV = 2'd0;
   localparam logic [1:0] PTR_CFG  = 2'd1;
   localparam logic [1:0] PTR_LO   = 2'd2;
   localparam logic [1:0] PTR_HI   = 2'd3;

   localparam logic [15:0] CONV_RST = 16'h0000;
   localparam logic [15:0] CFG_RST  = 16'h8583;
   localparam logic [15:0] LO_RST   = 16'h8000;
   localparam logic [15:0] HI_RST   = 16'h7FFF;

   // sel = 0 picks the MSB, sel = 1 the LSB of a read snapshot.
   function automatic logic [7:0] snap_byte(input logic [15:0] snap, input logic sel);
      if (sel) begin
         snap_byte = snap[7:0];
      end else begin
         snap_byte = snap[15:8];
      end
   endfunction

endpackage

// File: rtl/ads1115_i2c_target_i2c_bus_monitor.sv
// I2C line monitor: two-flop synchronisers plus a history flop per line,
// producing SCL edge strobes and START/STOP detection from synchronised levels.
module i2c_bus_monitor (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_lvl,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic scl_meta_r, scl_sync_r, scl_hist_r;
   logic sda_meta_r, sda_sync_r, sda_hist_r;

   // Synchroniser chains and history flops; idle bus level is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_meta_r <= 1'b1;
         scl_sync_r <= 1'b1;
         scl_hist_r <= 1'b1;
         sda_meta_r <= 1'b1;
         sda_sync_r <= 1'b1;
         sda_hist_r <= 1'b1;
      end else begin
         scl_meta_r <= scl_in;
         scl_sync_r <= scl_meta_r;
         scl_hist_r <= scl_sync_r;
         sda_meta_r <= sda_in;
         sda_sync_r <= sda_meta_r;
         sda_hist_r <= sda_sync_r;
      end
   end

   assign sda_lvl   = sda_sync_r;
   assign scl_rise  = scl_sync_r & ~scl_hist_r;
   assign scl_fall  = ~scl_sync_r & scl_hist_r;
   // SDA may only move while SCL is high for a START or STOP condition.
   assign start_det = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
   assign stop_det  = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;

endmodule

// File: rtl/ads1115_i2c_target.sv
// ADS1115-compatible I2C target register file (conversion, config, thresholds).
// Define ADS1115_TARGET_THRESH_EN to make pointers 2/3 real read/write registers.
module ads1115_i2c_target
   import ads1115_i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] conv_data,
   input  logic        conv_valid,
   output logic [15:0] cfg_reg,
   output logic        cfg_wr,
   output logic        os_start
);

   logic        sda_lvl_s, scl_rise_s, scl_fall_s, start_s, stop_s;
   logic [3:0]  state_r;
   logic [3:0]  bit_cnt_r;
   logic [7:0]  shift_r;
   logic        rw_r;
   logic [1:0]  ptr_r;
   logic [15:0] snap_r;
   logic        rd_sel_r;
   logic [1:0]  wbyte_r;
   logic [7:0]  msb_r;
   logic        ack_r;
   logic        sda_oe_r;
   logic [15:0] conv_r;
   logic [15:0] cfg_r;
   logic        cfg_wr_r;
   logic        os_start_r;
   logic [15:0] lo_val_s;
   logic [15:0] hi_val_s;
   logic [15:0] read_val_s;
   logic [7:0]  cur_byte_s;
   logic        rd_bit_s;
   logic        nxt_msb_s;
   logic        byte_done_s;
   logic        addr_match_s;
   logic        commit_s;
   logic [15:0] wdata_s;

   i2c_bus_monitor u_mon (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_lvl   (sda_lvl_s),
      .scl_rise  (scl_rise_s),
      .scl_fall  (scl_fall_s),
      .start_det (start_s),
      .stop_det  (stop_s)
   );

   assign byte_done_s  = scl_fall_s && (bit_cnt_r == 4'd8);
   assign addr_match_s = (shift_r[7:1] == DEV_ADDR);
   assign commit_s     = (state_r == ST_WDATA) && byte_done_s && (wbyte_r == 2'd1);
   assign wdata_s      = {msb_r, shift_r};

   // Read mux and the bit/byte currently being shifted out.
   always_comb begin
      cur_byte_s = snap_byte(snap_r, rd_sel_r);
      rd_bit_s   = cur_byte_s[3'd7 - bit_cnt_r[2:0]];
      nxt_msb_s  = rd_sel_r ? snap_r[15] : snap_r[7];
      case (ptr_r)
         PTR_CONV: read_val_s = conv_r;
         PTR_CFG:  read_val_s = cfg_r;
         PTR_LO:   read_val_s = lo_val_s;
         PTR_HI:   read_val_s = hi_val_s;
         default:  read_val_s = 16'h0000;
      endcase
   end

   // Protocol FSM; sda_oe only moves on SCL falls except on START/STOP/reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= 4'd0;
         shift_r   <= 8'h00;
         rw_r      <= 1'b0;
         ptr_r     <= PTR_CONV;
         snap_r    <= 16'h0000;
         rd_sel_r  <= 1'b0;
         wbyte_r   <= 2'd0;
         msb_r     <= 8'h00;
         ack_r     <= 1'b0;
         sda_oe_r  <= 1'b0;
      end else if (start_s) begin
         state_r   <= ST_ADDR;
         bit_cnt_r <= 4'd0;
         sda_oe_r  <= 1'b0;
      end else if (stop_s) begin
         state_r   <= ST_IDLE;
         sda_oe_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise_s) begin
                  shift_r   <= {shift_r[6:0], sda_lvl_s};
                  bit_cnt_r <= bit_cnt_r + 4'd1;
               end else if (byte_done_s) begin
                  if (state_r == ST_ADDR) begin
                     if (addr_match_s) begin
                        state_r  <= ST_ADDR_ACK;
                        sda_oe_r <= 1'b1;
                        rw_r     <= shift_r[0];
                        rd_sel_r <= 1'b0;
                        if (shift_r[0]) begin
                           snap_r <= read_val_s;
                        end
                     end else begin
                        state_r  <= ST_WAIT_STOP;
                        sda_oe_r <= 1'b0;
                     end
                  end else if (state_r == ST_PTR) begin
                     ptr_r    <= shift_r[1:0];
                     state_r  <= ST_PTR_ACK;
                     sda_oe_r <= 1'b1;
                  end else if (wbyte_r == 2'd2) begin
                     state_r  <= ST_WAIT_STOP;
                     sda_oe_r <= 1'b0;
                  end else begin
                     state_r  <= ST_WDATA_ACK;
                     sda_oe_r <= 1'b1;
                     if (wbyte_r == 2'd0) begin
                        msb_r <= shift_r;
                     end
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall_s) begin
                  bit_cnt_r <= 4'd0;
                  if (rw_r) begin
                     state_r  <= ST_RDATA;
                     sda_oe_r <= ~snap_r[15];
                  end else begin
                     state_r  <= ST_PTR;
                     sda_oe_r <= 1'b0;
                  end
               end
            end
            ST_PTR_ACK: begin
               if (scl_fall_s) begin
                  state_r   <= ST_WDATA;
                  bit_cnt_r <= 4'd0;
                  wbyte_r   <= 2'd0;
                  sda_oe_r  <= 1'b0;
               end
            end
            ST_WDATA_ACK: begin
               if (scl_fall_s) begin
                  state_r   <= ST_WDATA;
                  bit_cnt_r <= 4'd0;
                  sda_oe_r  <= 1'b0;
                  if (wbyte_r != 2'd2) begin
                     wbyte_r <= wbyte_r + 2'd1;
                  end
               end
            end
            ST_RDATA: begin
               if (scl_rise_s) begin
                  bit_cnt_r <= bit_cnt_r + 4'd1;
               end else if (byte_done_s) begin
                  state_r  <= ST_RDATA_ACK;
                  sda_oe_r <= 1'b0;
               end else if (scl_fall_s) begin
                  sda_oe_r <= ~rd_bit_s;
               end
            end
            ST_RDATA_ACK: begin
               if (scl_rise_s) begin
                  ack_r <= ~sda_lvl_s;
               end else if (scl_fall_s) begin
                  if (ack_r) begin
                     state_r   <= ST_RDATA;
                     rd_sel_r  <= ~rd_sel_r;
                     bit_cnt_r <= 4'd0;
                     sda_oe_r  <= ~nxt_msb_s;
                  end else begin
                     state_r  <= ST_WAIT_STOP;
                     sda_oe_r <= 1'b0;
                  end
               end
            end
            ST_IDLE, ST_WAIT_STOP: begin
               sda_oe_r <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               sda_oe_r <= 1'b0;
            end
         endcase
      end
   end

   // Conversion and config registers; cfg_wr/os_start pulse right after a commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_r     <= CONV_RST;
         cfg_r      <= CFG_RST;
         cfg_wr_r   <= 1'b0;
         os_start_r <= 1'b0;
      end else begin
         cfg_wr_r   <= 1'b0;
         os_start_r <= 1'b0;
         if (conv_valid) begin
            conv_r <= conv_data;
         end
         if (commit_s && (ptr_r == PTR_CFG)) begin
            cfg_r      <= wdata_s;
            cfg_wr_r   <= 1'b1;
            os_start_r <= msb_r[7];
         end
      end
   end

`ifdef ADS1115_TARGET_THRESH_EN
   logic [15:0] lo_r;
   logic [15:0] hi_r;

   // Threshold registers, written like the config register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_r <= LO_RST;
         hi_r <= HI_RST;
      end else if (commit_s) begin
         case (ptr_r)
            PTR_LO:  lo_r <= wdata_s;
            PTR_HI:  hi_r <= wdata_s;
            default: ;
         endcase
      end
   end

   assign lo_val_s = lo_r;
   assign hi_val_s = hi_r;
`else
   assign lo_val_s = 16'h0000;
   assign hi_val_s = 16'h0000;
`endif

   assign sda_oe   = sda_oe_r;
   assign cfg_reg  = cfg_r;
   assign cfg_wr   = cfg_wr_r;
   assign os_start = os_start_r;

endmodule

// File: tb/tb_ads1115_i2c_target.sv
// Bit-banged I2C master with a transaction-level register model; a per-cycle
// compare process checks the target against the model while SCL is high.
module tb_ads1115_i2c_target;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        conv_valid = 1'b0;
   logic [15:0] conv_data = 16'h0000;
   logic        sda_oe;
   logic [15:0] cfg_reg;
   logic        cfg_wr;
   logic        os_start;
   logic        sda_line;

   assign sda_line = sda_m & ~sda_oe;

   ads1115_i2c_target dut (
      .clk        (clk),
      .rst        (rst),
      .scl_in     (scl_m),
      .sda_in     (sda_line),
      .sda_oe     (sda_oe),
      .conv_data  (conv_data),
      .conv_valid (conv_valid),
      .cfg_reg    (cfg_reg),
      .cfg_wr     (cfg_wr),
      .os_start   (os_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state
   logic [15:0] conv_m, cfg_m, lo_m, hi_m;
   logic [1:0]  ptr_m;
   logic [7:0]  msb_m;
   int          exp_wr = 0, exp_os = 0, wr_seen = 0, os_seen = 0;
   logic        exp_oe = 1'b0, oe_win = 1'b0, no_drive = 1'b0, armed = 1'b0;
   logic [23:0] got;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] model_read(input logic [1:0] p);
      case (p)
         2'd0: return conv_m;
         2'd1: return cfg_m;
`ifdef ADS1115_TARGET_THRESH_EN
         2'd2: return lo_m;
         2'd3: return hi_m;
`endif
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_commit(input logic [7:0] lsb);
      if (ptr_m == 2'd1) begin
         cfg_m = {msb_m, lsb};
         exp_wr++;
         if (msb_m[7]) exp_os++;
      end
`ifdef ADS1115_TARGET_THRESH_EN
      if (ptr_m == 2'd2) lo_m = {msb_m, lsb};
      if (ptr_m == 2'd3) hi_m = {msb_m, lsb};
`endif
   endtask

   task automatic model_reset();
      conv_m = 16'h0000; cfg_m = 16'h8583; lo_m = 16'h8000; hi_m = 16'h7FFF;
      ptr_m = 2'd0; msb_m = 8'h00;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (armed) begin
         if (cfg_wr === 1'b1) wr_seen++;
         if (os_start === 1'b1) os_seen++;
         chk("os_without_wr", {31'd0, os_start & ~cfg_wr}, 32'd0);
         if (oe_win) begin
            chk("sda_oe", {31'd0, sda_oe}, {31'd0, exp_oe});
            chk("cfg_reg", {16'd0, cfg_reg}, {16'd0, cfg_m});
            chk("cfg_wr_count", wr_seen, exp_wr);
            chk("os_start_count", os_seen, exp_os);
         end
         if (no_drive) chk("no_drive", {31'd0, sda_oe}, 32'd0);
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_slot(input logic m, input logic e, output logic line);
      clks(4);
      sda_m = m;
      clks(4);
      exp_oe = e;
      scl_m = 1'b1;
      clks(1);
      oe_win = 1'b1;
      clks(6);
      line = sda_line;
      oe_win = 1'b0;
      clks(1);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      clks(4); sda_m = 1'b1;
      clks(4); scl_m = 1'b1;
      clks(8); sda_m = 1'b0;
      clks(8); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      clks(4); sda_m = 1'b0;
      clks(4); exp_oe = 1'b0; scl_m = 1'b1;
      clks(1); oe_win = 1'b1;
      clks(6); oe_win = 1'b0;
      clks(1); sda_m = 1'b1;
      clks(8);
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic ack, input bit commit);
      logic line;
      for (int i = 7; i >= 0; i--) bit_slot(b[i], 1'b0, line);
      if (commit) model_commit(b);
      bit_slot(1'b1, ack, line);
   endtask

   task automatic rd_byte(input logic [7:0] e, input logic nack, output logic [7:0] g);
      logic line;
      for (int i = 7; i >= 0; i--) begin
         bit_slot(1'b1, ~e[i], line);
         g[i] = line;
      end
      bit_slot(nack, 1'b0, line);
   endtask

   task automatic conv_pulse(input logic [15:0] v);
      conv_data = v; conv_valid = 1'b1;
      clks(1);
      conv_valid = 1'b0;
      conv_m = v;
   endtask

   task automatic write_txn(input logic [7:0] a, input int n, input logic [31:0] d, input bit do_stop);
      logic       match;
      logic [7:0] b;
      match = (a[7:1] == 7'h48) && (a[0] == 1'b0);
      i2c_start();
      wr_byte(a, match, 1'b0);
      for (int k = 0; k < n; k++) begin
         b = d[31-8*k -: 8];
         if (!match) wr_byte(b, 1'b0, 1'b0);
         else if (k == 0) begin wr_byte(b, 1'b1, 1'b0); ptr_m = b[1:0]; end
         else if (k == 1) begin msb_m = b; wr_byte(b, 1'b1, 1'b0); end
         else if (k == 2) wr_byte(b, 1'b1, 1'b1);
         else begin wr_byte(b, 1'b0, 1'b0); break; end
      end
      if (do_stop) i2c_stop();
   endtask

   task automatic read_txn(input int n, input bit mid, input logic [15:0] mid_val, output logic [23:0] g);
      logic [15:0] snap;
      logic [7:0]  gb, eb;
      g = 24'h0;
      i2c_start();
      wr_byte(8'h91, 1'b1, 1'b0);
      snap = model_read(ptr_m);
      for (int k = 0; k < n; k++) begin
         eb = (k % 2 == 0) ? snap[15:8] : snap[7:0];
         rd_byte(eb, (k == n - 1), gb);
         g = {g[15:0], gb};
         if (mid && k == 0) conv_pulse(mid_val);
      end
      i2c_stop();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic line;
      model_reset();
      rst = 1'b1;
      clks(3);
      rst = 1'b0;
      clks(2);
      armed = 1'b1;
      chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("rst_cfg_reg", {16'd0, cfg_reg}, 32'h8583);
      chk("rst_cfg_wr", {31'd0, cfg_wr}, 32'd0);
      chk("rst_os_start", {31'd0, os_start}, 32'd0);

      // config write with OS set
      write_txn(8'h90, 3, 32'h01848300, 1'b1);
      chk("cfg_8483", {16'd0, cfg_reg}, 32'h8483);
      chk("cfg_wr_once", wr_seen, 1);
      chk("os_once", os_seen, 1);

      // config write with OS clear
      write_txn(8'h90, 3, 32'h01058300, 1'b1);
      chk("cfg_0583", {16'd0, cfg_reg}, 32'h0583);
      chk("os_not_again", os_seen, 1);

      // extra data byte NACKed
      write_txn(8'h90, 4, 32'h01848355, 1'b1);
      chk("cfg_after_nack", {16'd0, cfg_reg}, 32'h8483);
      chk("cfg_wr_three", wr_seen, 3);

      // STOP before LSB: no update
      write_txn(8'h90, 2, 32'h01120000, 1'b1);
      chk("cfg_unchanged", {16'd0, cfg_reg}, 32'h8483);
      chk("cfg_wr_still_three", wr_seen, 3);

      // conversion read through repeated START
      conv_pulse(16'h1234);
      write_txn(8'h90, 1, 32'h00000000, 1'b0);
      read_txn(2, 1'b0, 16'h0, got);
      chk("conv_read", {8'd0, got}, 32'h1234);

      // other address never driven
      no_drive = 1'b1;
      write_txn(8'h92, 2, 32'h01840000, 1'b1);
      no_drive = 1'b0;

      // mid-read update stays out of the snapshot; wrap on next read
      read_txn(2, 1'b1, 16'hABCD, got);
      chk("snapshot_old", {8'd0, got}, 32'h1234);
      read_txn(3, 1'b0, 16'h0, got);
      chk("snapshot_new_wrap", {8'd0, got}, 32'hABCDAB);

      // threshold pointer 3
      write_txn(8'h90, 3, 32'h037F0000, 1'b1);
      write_txn(8'h90, 1, 32'h03000000, 1'b0);
      read_txn(2, 1'b0, 16'h0, got);
`ifdef ADS1115_TARGET_THRESH_EN
      chk("hi_thresh", {8'd0, got}, 32'h7F00);
`else
      chk("hi_thresh", {8'd0, got}, 32'h0000);
`endif

      // config readback
      write_txn(8'h90, 1, 32'h01000000, 1'b0);
      read_txn(2, 1'b0, 16'h0, got);
      chk("cfg_read", {8'd0, got}, 32'h8483);

      // reset while target drives an ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_slot(((8'h90 >> i) & 8'h01) != 8'h00, 1'b0, line);
      clks(4); sda_m = 1'b1;
      clks(4); exp_oe = 1'b1; scl_m = 1'b1;
      clks(1); oe_win = 1'b1;
      clks(3); oe_win = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("rst_mid_cfg", {16'd0, cfg_reg}, 32'h8583);
      model_reset();
      clks(2); rst = 1'b0;
      clks(3); scl_m = 1'b0;
      i2c_stop();
      write_txn(8'h90, 3, 32'h01848300, 1'b1);
      chk("cfg_after_rst_write", {16'd0, cfg_reg}, 32'h8483);

      clks(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
